// File: rtl/fx2_emu_pkg.sv
// Shared constants and types for the FX2 slave-FIFO host emulator.
package fx2_emu_pkg;

  localparam logic [1:0] FIFOADR_EP2 = 2'b00;
  localparam logic [1:0] FIFOADR_EP6 = 2'b10;

  localparam int FLG_EP2_NEMPTY = 0;
  localparam int FLG_EP6_NFULL  = 1;
  localparam int FLG_EP6_NPFULL = 2;

  localparam int ERR_STG_OVF  = 0;
  localparam int ERR_EP2_UNDR = 1;
  localparam int ERR_EP6_OVF  = 2;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } ep6_entry_t;

endpackage

// File: rtl/fx2_sync_fifo.sv
// Single-clock FIFO with occupancy count and an OR-in port for the newest entry.
module fx2_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  input  logic                     tail_set,
  input  logic [WIDTH-1:0]         tail_mask,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, tail_ptr;
  logic             push_ok, pop_ok;

  assign push_ok  = push && (count != CW'(DEPTH));
  assign pop_ok   = pop && (count != '0);
  assign tail_ptr = wr_ptr - AW'(1);
  assign dout     = mem[rd_ptr];

  // Tail marking and push never target the same slot unless full, where push is blocked.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= din;
    if (tail_set && (count != '0))
      mem[tail_ptr] <= mem[tail_ptr] | tail_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/fx2_host_emu.sv
// Host-side model of an FX2 slave FIFO: EP2 command buffer with staged commit,
// EP6 reply capture with packet-end marking and zero-length-packet counting.
module fx2_host_emu
  import fx2_emu_pkg::*;
#(
  parameter int CMD_DEPTH   = 16,
  parameter int REPLY_DEPTH = 64,
  parameter int PF_LEVEL    = REPLY_DEPTH - 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_wr,
  input  logic       cmd_commit,
  output logic       cmd_sent,
  input  logic [1:0] fifoadr,
  input  logic       slrd,
  input  logic       slwr,
  input  logic       sloe,
  input  logic       pktend,
  input  logic [7:0] fd_in,
  output logic [7:0] fd_out,
  output logic       fd_oe,
  output logic [2:0] flags,
  output logic [7:0] rep_data,
  output logic       rep_last,
  output logic       rep_valid,
  input  logic       rep_ready,
  output logic [2:0] err,
  output logic [7:0] zlp_count
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int PW  = CAW + 1;
  localparam int RCW = $clog2(REPLY_DEPTH) + 1;

  logic ep2_sel, ep6_sel;
  assign ep2_sel = (fifoadr == FIFOADR_EP2);
  assign ep6_sel = (fifoadr == FIFOADR_EP6);

  // ---------------- EP2: host -> device ----------------
  logic [7:0]    cmd_mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr;
  logic [PW-1:0] wr_nxt, cm_nxt, rd_nxt;
  logic          pending, pend_nxt, drained;
  logic          stg_ok, stg_ovf, rd_adv, ep2_undr;

  always_comb begin
    stg_ok   = cmd_wr && ((wr_ptr - rd_ptr) < PW'(CMD_DEPTH));
    stg_ovf  = cmd_wr && !stg_ok;
    rd_adv   = slrd && ep2_sel && (rd_ptr != cm_ptr);
    ep2_undr = slrd && ep2_sel && (rd_ptr == cm_ptr);
    wr_nxt   = wr_ptr + PW'(stg_ok);
    rd_nxt   = rd_ptr + PW'(rd_adv);
    cm_nxt   = cmd_commit ? wr_nxt : cm_ptr;
    pend_nxt = pending || cmd_commit;
    // Judged on next state so a commit landing on the drain cycle extends rather than double-pulses.
    drained  = pend_nxt && (rd_nxt == cm_nxt);
  end

  always_ff @(posedge clk) begin
    if (stg_ok)
      cmd_mem[wr_ptr[CAW-1:0]] <= cmd_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      cm_ptr   <= '0;
      rd_ptr   <= '0;
      pending  <= 1'b0;
      cmd_sent <= 1'b0;
    end else begin
      wr_ptr   <= wr_nxt;
      cm_ptr   <= cm_nxt;
      rd_ptr   <= rd_nxt;
      pending  <= pend_nxt && !drained;
      cmd_sent <= drained;
    end
  end

  assign fd_out = cmd_mem[rd_ptr[CAW-1:0]];
  assign fd_oe  = sloe && ep2_sel;

  // ---------------- EP6: device -> host ----------------
  ep6_entry_t     ep6_din, ep6_dout, ep6_mask;
  logic [RCW-1:0] ep6_cnt;
  logic           ep6_wr, ep6_end, ep6_full, ep6_push, ep6_pop;
  logic           ep6_ovf, tail_set, zlp_inc, pushed_since;

  always_comb begin
    ep6_wr   = slwr && ep6_sel;
    ep6_end  = pktend && ep6_sel;
    ep6_full = (ep6_cnt == RCW'(REPLY_DEPTH));
    ep6_push = ep6_wr && !ep6_full;
    ep6_ovf  = ep6_wr && ep6_full;
    ep6_pop  = rep_valid && rep_ready;
    ep6_din  = '{last: ep6_end, data: fd_in};
    ep6_mask = '{last: 1'b1, data: 8'h00};
    tail_set = ep6_end && !ep6_push && pushed_since;
    zlp_inc  = ep6_end && !ep6_push && !pushed_since;
  end

  fx2_sync_fifo #(
    .WIDTH ($bits(ep6_entry_t)),
    .DEPTH (REPLY_DEPTH)
  ) u_ep6 (
    .clk       (clk),
    .reset     (reset),
    .push      (ep6_push),
    .din       (ep6_din),
    .pop       (ep6_pop),
    .dout      (ep6_dout),
    .tail_set  (tail_set),
    .tail_mask (ep6_mask),
    .count     (ep6_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pushed_since <= 1'b0;
      zlp_count    <= '0;
    end else begin
      if (ep6_end)
        pushed_since <= 1'b0;
      else if (ep6_push)
        pushed_since <= 1'b1;
      if (zlp_inc && (zlp_count != 8'hFF))
        zlp_count <= zlp_count + 8'd1;
    end
  end

  assign rep_valid = (ep6_cnt != '0);
  assign rep_data  = ep6_dout.data;
  assign rep_last  = ep6_dout.last;

  // ---------------- status ----------------
  logic [2:0] err_set;

  always_comb begin
    err_set               = '0;
    err_set[ERR_STG_OVF]  = stg_ovf;
    err_set[ERR_EP2_UNDR] = ep2_undr;
    err_set[ERR_EP6_OVF]  = ep6_ovf;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= '0;
    else       err <= err | err_set;
  end

  // Decoded from registered pointers/count, so flags show post-edge state.
  always_comb begin
    flags                 = '0;
    flags[FLG_EP2_NEMPTY] = (rd_ptr != cm_ptr);
    flags[FLG_EP6_NFULL]  = !ep6_full;
    flags[FLG_EP6_NPFULL] = (ep6_cnt < RCW'(PF_LEVEL));
  end

endmodule

// File: doc/fx2_host_emu.md
FX2_HOST_EMU -- requirements
Module: fx2_host_emu

Interface
REQ-001 Parameter CMD_DEPTH, default 16, SHALL set EP2 (host-to-device) buffer depth in bytes; power of two, >=4.
REQ-002 Parameter REPLY_DEPTH, default 64, SHALL set EP6 (device-to-host) buffer depth in bytes; power of two, >=4.
REQ-003 Parameter PF_LEVEL, default REPLY_DEPTH-4, SHALL set the EP6 programmable-full threshold in bytes.
REQ-004 clk  in  1  the single clock; all logic samples on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cmd_data  in  8  host command byte; cmd_wr  in  1  stage the byte; cmd_commit  in  1  release staged bytes to the device.
REQ-007 cmd_sent  out  1  one-cycle pulse when all committed bytes have been read by the device.
REQ-008 fifoadr  in  2  device FIFO select (00 = EP2, 10 = EP6); slrd, slwr, sloe, pktend  in  1 each, active-high.
REQ-009 fd_in  in  8  device write data; fd_out  out  8  EP2 head byte; fd_oe  out  1  host drives fd.
REQ-010 flags  out  3  [0] EP2 empty_n, [1] EP6 full_n, [2] EP6 pfull_n.
REQ-011 rep_data  out  8, rep_last  out  1, rep_valid  out  1, rep_ready  in  1  captured-reply stream.
REQ-012 err  out  3  sticky: [0] staging overflow, [1] EP2 underrun, [2] EP6 overflow; zlp_count  out  8.

Function
REQ-013 EP2 SHALL be a circular buffer with write, commit and read pointers, each one bit wider than log2(CMD_DEPTH).
REQ-014 cmd_wr with occupancy (wr-rd) < CMD_DEPTH SHALL store cmd_data and advance wr; at full, the byte SHALL be dropped and err[0] set.
REQ-015 cmd_commit SHALL copy wr to commit and set pending; cmd_wr and cmd_commit in the same cycle SHALL include that byte.
REQ-016 Only bytes between rd and commit SHALL be visible; flags[0] SHALL be 1 when rd != commit, registered (reflects state after the edge).
REQ-017 fd_oe SHALL equal sloe && fifoadr==00; fd_out SHALL combinationally show the byte at rd.
REQ-018 slrd && fifoadr==00 && rd != commit SHALL advance rd; slrd on empty SHALL be ignored and set err[1].
REQ-019 When pending && rd == commit, cmd_sent SHALL pulse for exactly one cycle and pending SHALL clear; commit with zero staged bytes SHALL pulse cmd_sent on the next cycle.
REQ-020 A commit while pending SHALL extend commit; a single cmd_sent pulse SHALL follow the final drain.
REQ-021 slwr && fifoadr==10 SHALL push {last=0, fd_in} into EP6; at full, the byte SHALL be dropped and err[2] set.
REQ-022 pktend && fifoadr==10 SHALL set last on the most recently pushed, not yet popped entry; if no byte has been pushed since the previous pktend or since reset, zlp_count SHALL increment (saturating at 255).
REQ-023 slwr and pktend together SHALL push the byte with last=1.
REQ-024 flags[1] SHALL be 0 when EP6 count == REPLY_DEPTH; flags[2] SHALL be 0 when count >= PF_LEVEL; both registered.
REQ-025 rep_valid SHALL be 1 when EP6 is non-empty; a pop SHALL occur on rep_valid && rep_ready; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-026 Signals with fifoadr 01 or 11 SHALL have no effect.

Reset
REQ-027 Reset SHALL clear all pointers, pending, err, zlp_count and the EP6 count; cmd_sent=0, flags=3'b110, fd_oe follows sloe/fifoadr, rep_valid=0.
REQ-028 Reset mid-packet SHALL discard staged and committed bytes without pulsing cmd_sent.

Structure
REQ-029 Package fx2_emu_pkg SHALL hold the FIFO address constants (EP2=2'b00, EP6=2'b10), the flag bit indices and the err bit indices.
REQ-030 EP6 SHALL be a sub-module fx2_sync_fifo (parametrised width 9, depth REPLY_DEPTH, count output); EP2 logic SHALL stay inline.

Verification
REQ-031 Stage AA,01,03,04 and commit; device reads 4 bytes with slrd -> fd_out sequence AA,01,03,04, flags[0] falls after the 4th read, one cmd_sent pulse.
REQ-032 CMD_DEPTH=16; stage 17 bytes -> 16 bytes are stored, err[0]=1, the commit delivers exactly 16 bytes.
REQ-033 slrd held high with EP2 empty -> rd unchanged, err[1]=1, no cmd_sent pulse.
REQ-034 Device writes 3 bytes then pktend, then a lone pktend -> rep stream outputs 3 bytes with rep_last on the 3rd; zlp_count=1.
REQ-035 rep_ready=0, REPLY_DEPTH=64 writes -> flags[2] falls at count 60, flags[1] falls at 64; the 65th write sets err[2].
REQ-036 Assert reset with 2 committed bytes unread -> flags[0]=0, no cmd_sent pulse, err=0.
